// File: rtl/iccm_ctrl.sv
// ICCM port sequencer: splits 32-bit loader words into two halfword writes,
// performs registered 32-bit fetch reads, and owns the sticky boot_done flag.
module iccm_ctrl #(
    parameter int AddrWidth = 15,
    parameter int DataWidth = 32,
    parameter int HalfWord  = 16
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [AddrWidth-1:0] ld_addr,
    input  logic [DataWidth-1:0] ld_data,
    input  logic                 ld_done,
    input  logic                 if_req,
    output logic                 if_gnt,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_rvalid,
    output logic [DataWidth-1:0] if_rdata,
    output logic [AddrWidth-1:0] iccm_addr,
    output logic                 iccm_write,
    output logic                 iccm_read,
    output logic [DataWidth-1:0] iccm_wdata,
    input  logic [HalfWord-1:0]  iccm_rdata_lsb,
    input  logic [HalfWord-1:0]  iccm_rdata_msb,
    output logic                 boot_done
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, RD} state_t;

    state_t                 state, state_next;
    logic                   prefer;  // 0: loader wins a tie, 1: fetch wins a tie
    logic                   fetch_elig;
    logic [AddrWidth-1:0]   addr_q;  // A for writes, F for reads
    logic [DataWidth-1:0]   data_q;

    assign fetch_elig = if_req & boot_done;

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        if_gnt     = 1'b0;
        iccm_addr  = '0;
        iccm_write = 1'b0;
        iccm_read  = 1'b0;
        iccm_wdata = '0;
        case (state)
            IDLE: begin
                if (ld_valid && (!fetch_elig || !prefer)) begin
                    ld_ready   = 1'b1;
                    state_next = WR_LO;
                end else if (fetch_elig) begin
                    if_gnt     = 1'b1;
                    state_next = RD;
                end
            end
            WR_LO: begin
                iccm_write = 1'b1;
                iccm_addr  = addr_q;
                iccm_wdata = {{(DataWidth-HalfWord){1'b0}}, data_q[HalfWord-1:0]};
                state_next = WR_HI;
            end
            WR_HI: begin
                iccm_write = 1'b1;
                iccm_addr  = addr_q + AddrWidth'(1);
                iccm_wdata = {{(DataWidth-HalfWord){1'b0}}, data_q[2*HalfWord-1:HalfWord]};
                state_next = IDLE;
            end
            RD: begin
                iccm_read  = 1'b1;
                iccm_addr  = addr_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state     <= IDLE;
            prefer    <= 1'b0;
            boot_done <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state     <= state_next;
            if_rvalid <= (state == RD);
            if (ld_done)
                boot_done <= 1'b1;
            if (ld_ready) begin
                prefer <= 1'b1;
                addr_q <= ld_addr;
                data_q <= ld_data;
            end else if (if_gnt) begin
                prefer <= 1'b0;
                addr_q <= if_addr;
            end
            if (state == RD)
                if_rdata <= {iccm_rdata_msb, iccm_rdata_lsb};
        end
    end

endmodule
